alu_serial_rx: RTL
==================

# alu_serial_rx

DUT-side serial frame receiver for the ALU. It deserializes `sin` command frames (8 data packets, then 1 command packet) into operands B, A and the opcode. It checks framing, packet count, CRC4 and opcode validity, then presents either a one-cycle result strobe or a one-cycle error strobe to the ALU core. It is the responder counterpart of the testbench frame driver on `sin`.

## Interface
- `DATA_PKTS`, 8: data packets expected per frame (4 × B, then 4 × A, MSB byte first).
- `clk`  in  1: system clock; all logic on posedge.
- `rst_n`  in  1: synchronous, active-low reset.
- `sin`  in  1: serial input; idle high; one bit per clock.
- `out_valid`  out  1: one-cycle strobe, frame accepted.
- `b_out`  out  32: operand B, valid with `out_valid`, held until next strobe.
- `a_out`  out  32: operand A, as above.
- `op_out`  out  3: opcode (`operation_t`), as above.
- `err_valid`  out  1: one-cycle strobe, frame rejected.
- `err_flags`  out  3: {ERR_DATA, ERR_CRC, ERR_OP}, valid with `err_valid`, held until next strobe.

## Operation
- Packet: 11 bits. Bit 0 is start (0). Bit 1 is the type (0 = data, 1 = command). Bits 2..9 are the payload, MSB first. Bit 10 is stop (1).
- Command payload: {1'b0, op[2:0], crc[3:0]}.
- States:
  - IDLE: `sin`=0 → PKT, bit counter = 1.
  - PKT: shift bits 1..10. At bit 10 go to DECODE.
  - DECODE: one cycle, then → IDLE.
  - ABORT: wait for `sin`=1, then → IDLE.
- Data packet: shift the byte into a 64-bit {B,A} register. Increment the packet counter, saturating at 15.
- Command packet: the frame ends and is evaluated.
  - Counter ≠ DATA_PKTS → ERR_DATA only; CRC and op are not evaluated.
  - Otherwise ERR_CRC if the received crc ≠ computed CRC.
  - Otherwise (same condition) ERR_OP if op is not in {AND=000, OR=001, ADD=100, SUB=101}.
  - ERR_CRC and ERR_OP may both be set.
- No error: pulse `out_valid` and load `b_out`/`a_out`/`op_out`.
- Any error: pulse `err_valid` and load `err_flags`; operand outputs keep their old values.
- After evaluation, the packet counter and CRC state are cleared.
- Stop bit = 0 on any packet: pulse `err_valid` with ERR_DATA, clear the counter, go to ABORT.
- CRC4 parameters:
  - Polynomial x^4+x+1, initial value 0.
  - Message is {B, A, 1'b1, op}, 68 bits, MSB first.
  - Updated serially as payload bits arrive; the constant 1 is injected before the op bits.
- `out_valid` and `err_valid` are never high together.

## Timing
- Reset (`rst_n`=0 at posedge):
  - State = IDLE; counter and CRC state = 0.
  - All outputs = 0.
  - Takes effect mid-frame: the partial frame is discarded with no strobe.
- `sin` is sampled on posedge (the driver changes it after negedge).
- Strobe latency: exactly 2 cycles after the posedge that samples the command stop bit (one DECODE cycle, then a registered output).
- Back-to-back: a start bit is accepted in the cycle after DECODE. Minimum gap between packets is 1 idle bit; consecutive frames need no extra idle time.
- A start bit in the DECODE cycle is ignored. The driver guarantees at least one idle bit between packets.
- More than 8 data packets before a command → ERR_DATA at the command; the counter saturates and does not wrap.
- Idle `sin`=1 forever: no strobes.

## Structure
- `alu_pkg` holds:
  - `operation_t`, including the testbench-only RST=111, which is always ERR_OP here;
  - the error-flag bit positions;
  - packet width (11), data/command type values, and the CRC4 polynomial constant.
- Sub-module `alu_crc4`: serial LFSR with `clk`, `rst_n`, `clr`, `en`, `din` inputs and a `crc[3:0]` output. It is instantiated once.
- Top level contains the FSM, the bit and packet counters, the shift registers and the output registers.

## Test plan
- A=0, B=0, op=AND, crc=4'b1011 → `out_valid` for 1 cycle, `a_out`=0, `b_out`=0, `op_out`=000, `err_valid`=0.
- Same frame with crc=4'b0000 → `err_valid`, `err_flags`=3'b010, `a_out`/`b_out` unchanged.
- Frame with 7 data packets then a command → `err_valid`, `err_flags`=3'b100.
- Valid-CRC frame with op=3'b111 → `err_flags`=3'b001. With a wrong CRC as well → 3'b011.
- Stop bit forced to 0 in data packet 3 → ERR_DATA strobe immediately. `sin` held low 5 cycles, then a correct frame → `out_valid` with the correct operands.
- `rst_n` low for 1 cycle during packet 5, then a correct frame A=0x12345678, B=0x9ABCDEF0, op=ADD with model CRC → exactly one `out_valid` with those values, and no strobe from the aborted frame.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, error-flag, packet-format and CRC constants for the ALU serial link
package alu_pkg;

    typedef enum logic [2:0] {
        AND_OP = 3'b000,
        OR_OP  = 3'b001,
        ADD_OP = 3'b100,
        SUB_OP = 3'b101,
        RST_OP = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PKT,
        S_DECODE,
        S_ABORT
    } rx_state_t;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    localparam int         PKT_BITS  = 11;
    localparam logic       TYPE_DATA = 1'b0;
    localparam logic       TYPE_CMD  = 1'b1;
    localparam logic [3:0] CRC_POLY  = 4'b0011;

    // RST is a bench-only opcode, so the receiver treats it as invalid
    function automatic logic op_valid(input logic [2:0] op);
        return op inside {AND_OP, OR_OP, ADD_OP, SUB_OP};
    endfunction

endpackage

// File: rtl/alu_crc4.sv
// alu_crc4: serial CRC4 (x^4+x+1) LFSR, MSB-first, synchronous clear
module alu_crc4
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [3:0] crc
);

    logic fb;

    assign fb = crc[3] ^ din;

    // shift one message bit per enabled cycle
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            crc <= 4'b0;
        else if (en)
            crc <= {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0);
    end

endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserializes sin frames into ALU operands/opcode with framing, count, CRC and opcode checks
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int DATA_PKTS = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] b_out,
    output logic [31:0] a_out,
    output operation_t  op_out,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    rx_state_t   state;
    logic [3:0]  bit_cnt;
    logic [3:0]  pkt_cnt;
    logic        is_cmd;
    logic [7:0]  payload;
    logic [63:0] ba;
    logic [3:0]  crc;
    logic        crc_clr;
    logic        crc_en;
    logic        crc_din;
    logic        stop_bit;
    logic        cnt_bad;
    logic [2:0]  flags;

    assign stop_bit = state == S_PKT && bit_cnt == 4'(PKT_BITS - 1);
    assign crc_clr  = (state == S_DECODE && is_cmd) || (stop_bit && !sin);
    assign crc_en   = state == S_PKT && bit_cnt >= 4'd2 && bit_cnt <= (is_cmd ? 4'd5 : 4'd9);
    assign crc_din  = (is_cmd && bit_cnt == 4'd2) ? 1'b1 : sin;

    alu_crc4 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

    // a bad packet count masks the CRC and opcode checks
    always_comb begin
        cnt_bad         = pkt_cnt != 4'(DATA_PKTS);
        flags           = '0;
        flags[ERR_DATA] = cnt_bad;
        flags[ERR_CRC]  = !cnt_bad && payload[3:0] != crc;
        flags[ERR_OP]   = !cnt_bad && !op_valid(payload[6:4]);
    end

    // receive FSM with registered strobes and held result/error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            pkt_cnt   <= '0;
            is_cmd    <= 1'b0;
            payload   <= '0;
            ba        <= '0;
            out_valid <= 1'b0;
            b_out     <= '0;
            a_out     <= '0;
            op_out    <= AND_OP;
            err_valid <= 1'b0;
            err_flags <= '0;
        end else begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!sin) begin
                        state   <= S_PKT;
                        bit_cnt <= 4'd1;
                    end
                end
                S_PKT: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd1)
                        is_cmd <= sin == TYPE_CMD;
                    else if (!stop_bit)
                        payload <= {payload[6:0], sin};
                    else if (sin)
                        state <= S_DECODE;
                    else begin
                        err_valid <= 1'b1;
                        err_flags <= 3'b1 << ERR_DATA;
                        pkt_cnt   <= '0;
                        state     <= S_ABORT;
                    end
                end
                S_DECODE: begin
                    state <= S_IDLE;
                    if (!is_cmd) begin
                        ba      <= {ba[55:0], payload};
                        pkt_cnt <= (pkt_cnt == 4'd15) ? pkt_cnt : pkt_cnt + 4'd1;
                    end else begin
                        pkt_cnt <= '0;
                        if (flags == 3'b0) begin
                            out_valid <= 1'b1;
                            b_out     <= ba[63:32];
                            a_out     <= ba[31:0];
                            op_out    <= operation_t'(payload[6:4]);
                        end else begin
                            err_valid <= 1'b1;
                            err_flags <= flags;
                        end
                    end
                end
                S_ABORT: begin
                    if (sin)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
